wheel_quadrature_decoder: RTL
=============================

// Module: wheel_quadrature_decoder
// PURPOSE
//  Front end of the wheel-speed path. Decodes a 2-channel quadrature encoder (enc_a/enc_b) into
//  1-cycle conta_CW / conta_CWW pulses, one per valid Gray transition (x4 decoding).
//  Also times the measurement window: emits registra then zera, which drive the downstream
//  interface_wheel_fd counters and register. Pulses are never dropped at a window boundary.
// PARAMETERS
//  DEBOUNCE_CYCLES  4      consecutive stable samples before a channel change is accepted; legal range >=2
//  WINDOW_CYCLES    50000  clocks per measurement window; legal range >=4
//  WIN_W            16     timer width; must hold WINDOW_CYCLES-1
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high; clears all state
//  enc_a      in   1  encoder channel A, asynchronous to clk
//  enc_b      in   1  encoder channel B, asynchronous to clk
//  enable     in   1  1 = window timer runs; 0 = timer held at 0, no registra/zera
//  clr_erro   in   1  synchronous clear of erro
//  conta_CW   out  1  1-cycle pulse: one CW transition
//  conta_CWW  out  1  1-cycle pulse: one CCW transition
//  registra   out  1  1-cycle pulse: store the net count downstream
//  zera       out  1  1-cycle pulse: clear the downstream counters; cycle after registra
//  erro       out  1  sticky: illegal transition seen (both channels changed at once)
// BEHAVIOUR
//  Reset: every output 0, timer 0, pending flags 0, filters 0, decoder FSM = INIT.
//  Sync: 2-flop synchronizer per channel.
//  Debounce: per channel, filtered value takes the synced value once they have differed
//   for DEBOUNCE_CYCLES consecutive clocks. Any agreement resets the run counter.
//  Decoder FSM:
//   - INIT: filtered values are copied into prev every cycle. No pulses, no erro.
//   - INIT -> RUN: after DEBOUNCE_CYCLES+3 clocks.
//   - RUN: compare prev={a,b} with current filtered value.
//     - CW sequence 00->01->11->10->00 gives a CW pulse; the reverse gives a CCW pulse.
//     - Unchanged: nothing.
//     - Both bits changed: erro<=1, no pulse. prev is updated in every case.
//  Latency: channel change stable at pin -> conta_* pulse = DEBOUNCE_CYCLES+3 clocks, fixed.
//  Window timer FSM:
//   - COUNT: increments each cycle while enable=1. Goes to REG at WINDOW_CYCLES-1.
//   - REG: registra=1 for one cycle, then ZERA.
//   - ZERA: zera=1 for one cycle, then COUNT with timer=0.
//   - Window period is WINDOW_CYCLES+2 clocks.
//   - enable=0 in any state: go to COUNT with timer=0, no pulse. A started REG always completes its ZERA.
//  Blackout:
//   - A decoded pulse in a REG or ZERA cycle is not output. It sets pending_CW or pending_CWW instead.
//   - Pending pulses are emitted in the cycle after ZERA and then cleared.
//   - Minimum transition spacing (>=3 clocks) guarantees at most one pulse per blackout.
//   - conta_CW and conta_CWW are never both 1.
//  erro: set in RUN on an illegal transition; cleared by clr_erro or reset. Set wins over a same-cycle clr_erro.
//  Reset mid-operation: immediate clear, pending pulses dropped, FSM back to INIT. No pulse, no erro on exit.
// TESTING
//  1. Reset, hold A/B=11 through INIT -> no pulses, erro=0. Then 11->10 -> one conta_CW exactly 7 clocks later (DEB=4).
//  2. Full CW cycle x4 (00,01,11,10,00) -> 4 conta_CW, 0 conta_CWW. Reverse sequence -> 4 conta_CWW.
//  3. 1-2 cycle glitch on A (DEB=4) -> no pulse, erro=0. Then A,B toggled on the same clock -> erro=1, no pulse.
//     clr_erro -> erro=0.
//  4. WINDOW_CYCLES=8, enable=1 -> registra at cycle 8, zera at 9, period 10. enable=0 mid-window -> no registra.
//  5. CW transition timed to decode during the REG cycle -> no pulse in REG/ZERA, conta_CW in the cycle after zera.
//  6. Assert reset while a pending pulse is held and erro=1 -> all outputs 0. After release, no spurious pulse or erro.

Source files
------------

// File: rtl/wheel_quadrature_decoder.sv
// Wheel-speed front end: synchronizes and debounces a 2-channel quadrature
// encoder, decodes x4 CW/CCW pulses and times the measurement window that
// drives the downstream registra/zera handshake. Pulses that fall inside the
// registra/zera blackout are held and emitted right after zera.
module wheel_quadrature_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WINDOW_CYCLES   = 50000,
    parameter int WIN_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enable,
    input  logic clr_erro,
    output logic conta_CW,
    output logic conta_CWW,
    output logic registra,
    output logic zera,
    output logic erro
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 4);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 2);
    localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);

    typedef enum logic {
        DEC_INIT,
        DEC_RUN
    } dec_state_t;

    typedef enum logic [1:0] {
        WIN_COUNT,
        WIN_REG,
        WIN_ZERA
    } win_state_t;

    // Channel vectors are packed as {a, b}.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_filt;
    logic [DEB_W-1:0] r_deb_cnt [2];

    dec_state_t        r_dec_state;
    dec_state_t        w_dec_next;
    logic [INIT_W-1:0] r_init_cnt;
    logic [1:0]        r_prev;
    logic              w_cw;
    logic              w_ccw;
    logic              w_illegal;
    logic              r_dec_cw;
    logic              r_dec_ccw;
    logic              r_erro;

    win_state_t       r_win_state;
    win_state_t       w_win_next;
    logic [WIN_W-1:0] r_timer;
    logic [WIN_W-1:0] w_timer_next;

    logic w_blk;
    logic r_emit;
    logic r_pend_cw;
    logic r_pend_ccw;
    logic w_out_cw;
    logic w_out_ccw;

    // Two-flop synchronizer for both asynchronous encoder channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {enc_a, enc_b};
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES clocks in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_filt[i]    <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_ONE;
                end
            end
        end
    end

    // Decoder next state and Gray-transition classification of prev -> filtered.
    always_comb begin
        w_dec_next = r_dec_state;
        w_cw       = 1'b0;
        w_ccw      = 1'b0;
        w_illegal  = 1'b0;
        case (r_dec_state)
            DEC_INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_dec_next = DEC_RUN;
                end
            end
            DEC_RUN: begin
                case ({r_prev, r_filt})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: w_cw      = 1'b1;
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: w_ccw     = 1'b1;
                    4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;
                    default: ;
                endcase
            end
            default: w_dec_next = DEC_INIT;
        endcase
    end

    // Decoder state, previous value tracking, registered pulses and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dec_state <= DEC_INIT;
            r_init_cnt  <= '0;
            r_prev      <= 2'b00;
            r_dec_cw    <= 1'b0;
            r_dec_ccw   <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_dec_state <= w_dec_next;
            if (r_dec_state == DEC_INIT) begin
                r_init_cnt <= r_init_cnt + INIT_ONE;
            end
            r_prev    <= r_filt;
            r_dec_cw  <= w_cw;
            r_dec_ccw <= w_ccw;
            if (w_illegal) begin
                r_erro <= 1'b1;
            end else if (clr_erro) begin
                r_erro <= 1'b0;
            end
        end
    end

    // Window timer next state: count to WINDOW_CYCLES-1, then one REG and one ZERA cycle.
    always_comb begin
        w_win_next   = r_win_state;
        w_timer_next = '0;
        case (r_win_state)
            WIN_COUNT: begin
                if (enable) begin
                    if (r_timer == WIN_LAST) begin
                        w_win_next = WIN_REG;
                    end else begin
                        w_timer_next = r_timer + WIN_ONE;
                    end
                end
            end
            WIN_REG:  w_win_next = WIN_ZERA;
            WIN_ZERA: w_win_next = WIN_COUNT;
            default:  w_win_next = WIN_COUNT;
        endcase
    end

    // Window timer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_state <= WIN_COUNT;
            r_timer     <= '0;
        end else begin
            r_win_state <= w_win_next;
            r_timer     <= w_timer_next;
        end
    end

    assign w_blk = (r_win_state == WIN_REG) || (r_win_state == WIN_ZERA);

    // Hold pulses decoded during the blackout and release them in the cycle after ZERA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_emit     <= 1'b0;
            r_pend_cw  <= 1'b0;
            r_pend_ccw <= 1'b0;
        end else begin
            r_emit <= (r_win_state == WIN_ZERA);
            if (w_blk && r_dec_cw) begin
                r_pend_cw <= 1'b1;
            end else if (r_emit) begin
                r_pend_cw <= 1'b0;
            end
            if (w_blk && r_dec_ccw) begin
                r_pend_ccw <= 1'b1;
            end else if (r_emit) begin
                r_pend_ccw <= 1'b0;
            end
        end
    end

    assign w_out_cw  = !w_blk && (r_dec_cw || (r_emit && r_pend_cw));
    assign w_out_ccw = !w_blk && !w_out_cw && (r_dec_ccw || (r_emit && r_pend_ccw));

    assign conta_CW  = w_out_cw;
    assign conta_CWW = w_out_ccw;
    assign registra  = (r_win_state == WIN_REG);
    assign zera      = (r_win_state == WIN_ZERA);
    assign erro      = r_erro;

endmodule
